dcca_ce_ctrl: RTL and testbench
===============================

# dcca_ce_ctrl

Synchronous clock-enable sequencer that drives the CE input of the DCCA clock-gate buffer in front of the DDR3 PHY/controller clock tree. It gates the downstream clock off after a programmable idle period or on an explicit stop request, and restores it on activity or wake. Minimum on/off dwell times are enforced so the gated clock never pulses shorter than the DCCA and PLL loads tolerate. It runs on the ungated source clock, the same net that feeds DCCA CLKI.

## Interface
- IDLE_CYCLES, 16: consecutive BUSY-low cycles in ON before auto-gating; 0 disables auto-gating.
- MIN_ON, 4: minimum cycles CE stays high after rising, including the reset release.
- MIN_OFF, 4: minimum cycles CE stays low after falling.
- CNT_W, 8: width of the idle and dwell counters; all other parameters must be < 2^CNT_W.

- CLK  in  1  ungated source clock, same net as DCCA CLKI.
- RST  in  1  synchronous, active-high reset.
- STOP_REQ  in  1  level request to stop the clock; held until released.
- STOP_ACK  out  1  high while CE is low because of STOP_REQ.
- BUSY  in  1  downstream activity; blocks gating and wakes from idle-off.
- WAKE  in  1  single-cycle or level wake request, used in idle-off only.
- CE  out  1  registered clock enable to DCCA CE.
- GATED  out  1  high whenever CE is low (registered copy, same timing as CE).

## Operation
- States: ON (CE=1), OFF_IDLE (CE=0, entered by idle timeout), OFF_REQ (CE=0, entered by STOP_REQ).
- Reset: state ON, CE=1, GATED=0, STOP_ACK=0, idle counter 0, dwell counter 0, wake_pend 0.
- Idle counter in ON:
  - Increments each cycle BUSY=0, saturating at IDLE_CYCLES.
  - Clears on any BUSY=1 cycle and on entry to ON.
- Dwell counter:
  - Clears on every state change.
  - Increments each cycle, saturating at max(MIN_ON, MIN_OFF).
- ON → OFF_REQ: STOP_REQ=1 && BUSY=0 && dwell ≥ MIN_ON.
- ON → OFF_IDLE: IDLE_CYCLES≠0 && idle = IDLE_CYCLES && BUSY=0 && STOP_REQ=0 && dwell ≥ MIN_ON.
- STOP_REQ has priority over idle when both qualify.
- BUSY=1 blocks both exits; the stop request stays pending, with no ack.
- OFF_IDLE:
  - BUSY=1 or WAKE=1 sets wake_pend.
  - → ON when (wake_pend or BUSY or WAKE) && dwell ≥ MIN_OFF.
  - STOP_REQ=1 while in OFF_IDLE → OFF_REQ. CE stays low and the dwell counter does not clear.
- OFF_REQ:
  - BUSY and WAKE are ignored.
  - → ON when STOP_REQ=0 && dwell ≥ MIN_OFF.
  - If STOP_REQ drops during the dwell, the exit happens the cycle dwell reaches MIN_OFF.
- STOP_ACK = (state == OFF_REQ). It rises with CE falling and falls with CE rising.
- wake_pend clears on entry to ON.
- Reset mid-operation forces ON/CE=1 on the next edge regardless of STOP_REQ.
- Because of the MIN_ON rule, the first stop can take effect no earlier than MIN_ON cycles after reset release.

## Timing
- Decision in cycle N → state, CE, GATED and STOP_ACK update at the edge ending cycle N. Inputs affect CE after exactly one register delay.
- CE is driven directly from a flop with no combinational path from inputs, so it is glitch-free into DCCA.
- Minimum high pulse of CE = MIN_ON cycles; minimum low pulse = MIN_OFF cycles (parameter values ≥ 1).
- Handshake: requester raises STOP_REQ and waits for STOP_ACK=1, then may release STOP_REQ. CE returns high ≥ 1 cycle after release and no earlier than MIN_OFF cycles after STOP_ACK rose.
- With BUSY held low and STOP_REQ=0, CE falls IDLE_CYCLES+1 edges after BUSY last seen high, subject to MIN_ON.

## Structure
- Shared package dcca_ctrl_pkg: state encodings ST_ON=2'd0, ST_OFF_IDLE=2'd1, ST_OFF_REQ=2'd2 and the default parameter values.
- One natural sub-module, dcca_dwell_cnt: saturating CNT_W counter with sync clear. Instantiate it twice (idle counter, dwell counter).
- Top level instantiates the FSM and drives DCCA CE directly; DCCA itself is not instantiated inside this block.

## Test plan
- Reset release, BUSY=0, defaults → CE=1 for cycles 0..16; CE=0 and GATED=1 at edge 17; STOP_ACK stays 0.
- In OFF_IDLE, one-cycle WAKE pulse 1 cycle after CE fell (MIN_OFF=4) → wake_pend held; CE rises exactly 4 cycles after it fell.
- STOP_REQ=1 with BUSY=1 for 10 cycles, then BUSY=0 → CE and STOP_ACK stay 1/0 during BUSY; CE=0 and STOP_ACK=1 one edge after BUSY drops. Release STOP_REQ after 8 cycles → CE=1 and STOP_ACK=0 the next edge.
- In OFF_REQ, BUSY=1 and WAKE=1 asserted → CE stays 0; raising STOP_REQ during OFF_IDLE moves to OFF_REQ with STOP_ACK=1 and CE never glitching high.
- IDLE_CYCLES=0, BUSY=0 for 100 cycles → CE never falls. Then STOP_REQ=1 → CE falls one edge later.
- RST asserted while in OFF_REQ with STOP_REQ=1 → next edge CE=1, STOP_ACK=0. After release, CE remains 1 for MIN_ON cycles before re-gating.

Source files
------------

// File: rtl/dcca_ctrl_pkg.sv
// Shared types and default parameters for the DCCA clock-enable sequencer.
package dcca_ctrl_pkg;

  localparam int unsigned IDLE_CYCLES_DEF = 16;
  localparam int unsigned MIN_ON_DEF      = 4;
  localparam int unsigned MIN_OFF_DEF     = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_ON       = 2'd0,
    ST_OFF_IDLE = 2'd1,
    ST_OFF_REQ  = 2'd2
  } dcca_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dcca_dwell_cnt.sv
// Saturating up-counter with synchronous clear, used for idle and dwell timing.
module dcca_dwell_cnt #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins; otherwise count up and hold at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q < MAX_C) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcca_ce_ctrl.sv
// Clock-enable sequencer for the DCCA gate in front of the DDR3 clock tree.
// CE, GATED and STOP_ACK are flops so CE reaches DCCA glitch-free.
module dcca_ce_ctrl
  import dcca_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned MIN_ON      = MIN_ON_DEF,
  parameter int unsigned MIN_OFF     = MIN_OFF_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stop_req_i,
  input  logic busy_i,
  input  logic wake_i,
  output logic stop_ack_o,
  output logic ce_o,
  output logic gated_o
);

  localparam int unsigned      DWELL_MAX = max_u(MIN_ON, MIN_OFF);
  localparam logic [CNT_W-1:0] IDLE_C    = CNT_W'(IDLE_CYCLES);
  // The dwell counter reads 0 in the first cycle of a state, so the current
  // cycle completes the dwell when the count reaches MIN-1.
  localparam logic [CNT_W-1:0] ON_M1     = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_M1    = CNT_W'(MIN_OFF - 1);
  localparam bit               IDLE_EN   = (IDLE_CYCLES != 0);

  dcca_state_e      state_q, state_d;
  logic             wake_pend_q, wake_pend_d;
  logic             ce_q, ce_d;
  logic             gated_q, gated_d;
  logic             stop_ack_q, stop_ack_d;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] dwell_cnt;
  logic             idle_clr;
  logic             dwell_clr;
  logic             on_ok;
  logic             off_ok;

  // Idle counter only runs in ON; any busy cycle restarts it.
  assign idle_clr = busy_i || (state_q != ST_ON);
  assign on_ok    = (dwell_cnt >= ON_M1);
  assign off_ok   = (dwell_cnt >= OFF_M1);

  dcca_dwell_cnt #(
    .CNT_W (CNT_W),
    .MAX   (IDLE_CYCLES)
  ) u_idle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (idle_clr),
    .cnt_o (idle_cnt)
  );

  dcca_dwell_cnt #(
    .CNT_W (CNT_W),
    .MAX   (DWELL_MAX)
  ) u_dwell_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (dwell_clr),
    .cnt_o (dwell_cnt)
  );

  // State, wake latch and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ON;
      wake_pend_q <= 1'b0;
      ce_q        <= 1'b1;
      gated_q     <= 1'b0;
      stop_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_pend_q <= wake_pend_d;
      ce_q        <= ce_d;
      gated_q     <= gated_d;
      stop_ack_q  <= stop_ack_d;
    end
  end

  // Next-state decision, wake latch and dwell restart.
  always_comb begin
    state_d     = state_q;
    wake_pend_d = wake_pend_q;
    dwell_clr   = 1'b0;
    case (state_q)
      ST_ON: begin
        if (!busy_i && on_ok) begin
          if (stop_req_i) begin
            state_d = ST_OFF_REQ;
          end else if (IDLE_EN && (idle_cnt == IDLE_C)) begin
            state_d = ST_OFF_IDLE;
          end
        end
      end
      ST_OFF_IDLE: begin
        if (busy_i || wake_i) begin
          wake_pend_d = 1'b1;
        end
        if (stop_req_i) begin
          state_d = ST_OFF_REQ;
        end else if ((wake_pend_q || busy_i || wake_i) && off_ok) begin
          state_d = ST_ON;
        end
      end
      ST_OFF_REQ: begin
        if (!stop_req_i && off_ok) begin
          state_d = ST_ON;
        end
      end
      default: begin
        state_d = ST_ON;
      end
    endcase
    // Idle-off to request-off keeps CE low, so its low dwell keeps running.
    if ((state_d != state_q) &&
        !((state_q == ST_OFF_IDLE) && (state_d == ST_OFF_REQ))) begin
      dwell_clr = 1'b1;
    end
    if ((state_d == ST_ON) && (state_q != ST_ON)) begin
      wake_pend_d = 1'b0;
    end
  end

  // Output values for the next state.
  always_comb begin
    ce_d       = 1'b0;
    gated_d    = 1'b1;
    stop_ack_d = 1'b0;
    if (state_d == ST_ON) begin
      ce_d    = 1'b1;
      gated_d = 1'b0;
    end
    if (state_d == ST_OFF_REQ) begin
      stop_ack_d = 1'b1;
    end
  end

  assign ce_o       = ce_q;
  assign gated_o    = gated_q;
  assign stop_ack_o = stop_ack_q;

endmodule

// File: tb/tb_dcca_ce_ctrl.sv
// Bench for dcca_ce_ctrl: two instances (idle timeout 16 and 0) on shared
// stimulus, a cycle-level behavioural model, and directed literal checks.
module tb_dcca_ce_ctrl;

  localparam int T_MIN_ON  = 4;
  localparam int T_MIN_OFF = 4;

  logic clk;
  logic rst, stop_req, busy, wake;
  logic ce_a, gated_a, ack_a;
  logic ce_b, gated_b, ack_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: 0 = clock on, 1 = off after idle, 2 = off on request.
  int m_mode  [2] = '{0, 0};
  int m_run   [2] = '{0, 0};
  int m_quiet [2] = '{0, 0};
  bit m_pend  [2] = '{0, 0};
  int m_idle  [2] = '{16, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dcca_ce_ctrl #(
    .IDLE_CYCLES (16),
    .MIN_ON      (T_MIN_ON),
    .MIN_OFF     (T_MIN_OFF),
    .CNT_W       (8)
  ) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .stop_req_i (stop_req),
    .busy_i     (busy),
    .wake_i     (wake),
    .stop_ack_o (ack_a),
    .ce_o       (ce_a),
    .gated_o    (gated_a)
  );

  dcca_ce_ctrl #(
    .IDLE_CYCLES (0),
    .MIN_ON      (T_MIN_ON),
    .MIN_OFF     (T_MIN_OFF),
    .CNT_W       (8)
  ) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .stop_req_i (stop_req),
    .busy_i     (busy),
    .wake_i     (wake),
    .stop_ack_o (ack_b),
    .ce_o       (ce_b),
    .gated_o    (gated_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // One clock edge of the model: phase lengths counted in whole cycles.
  task automatic model_step(input int k);
    int nm;
    bit ok_on, ok_off;
    if (rst) begin
      m_mode[k] = 0; m_run[k] = 0; m_quiet[k] = 0; m_pend[k] = 0;
      return;
    end
    nm     = m_mode[k];
    ok_on  = (m_run[k] + 1 >= T_MIN_ON);
    ok_off = (m_run[k] + 1 >= T_MIN_OFF);
    case (m_mode[k])
      0: begin
        m_quiet[k] = busy ? 0 : m_quiet[k] + 1;
        if (!busy && ok_on && stop_req) nm = 2;
        else if (!busy && ok_on && m_idle[k] != 0 && m_quiet[k] > m_idle[k]) nm = 1;
      end
      1: begin
        if (busy || wake) m_pend[k] = 1;
        if (stop_req) nm = 2;
        else if (m_pend[k] && ok_off) nm = 0;
      end
      default: begin
        if (!stop_req && ok_off) nm = 0;
      end
    endcase
    if (nm == m_mode[k] || (m_mode[k] == 1 && nm == 2)) m_run[k]++;
    else m_run[k] = 0;
    if (nm == 0 && m_mode[k] != 0) begin
      m_quiet[k] = 0;
      m_pend[k]  = 0;
    end
    m_mode[k] = nm;
  endtask

  // Per-cycle comparison of both instances against the model.
  always begin
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("cyc_ce_a",    ce_a,    m_mode[0] == 0);
    chk("cyc_gated_a", gated_a, m_mode[0] != 0);
    chk("cyc_ack_a",   ack_a,   m_mode[0] == 2);
    chk("cyc_ce_b",    ce_b,    m_mode[1] == 0);
    chk("cyc_gated_b", gated_b, m_mode[1] != 0);
    chk("cyc_ack_b",   ack_b,   m_mode[1] == 2);
  end

  initial begin
    int n, fall, rise, fa, fb, bad, ack_seen, low;
    rst = 1'b1; stop_req = 1'b0; busy = 1'b0; wake = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ce_a",  ce_a,    1);
    chk("rst_gat_a", gated_a, 0);
    chk("rst_ack_a", ack_a,   0);
    chk("rst_ce_b",  ce_b,    1);
    rst = 1'b0;

    // Idle timeout from reset release.
    n = 0; fall = 0; ack_seen = 0;
    while (fall == 0 && n < 40) begin
      @(negedge clk); n++;
      if (!ce_a) fall = n;
      if (ack_a) ack_seen = 1;
    end
    chk("idle_fall_edge", fall, 17);
    chk("idle_gated",     gated_a, 1);
    chk("idle_no_ack",    ack_seen, 0);
    chk("idle0_still_on", ce_b, 1);

    // One-cycle wake pulse must be remembered until MIN_OFF elapses.
    @(negedge clk); wake = 1'b1;
    @(negedge clk); wake = 1'b0;
    n = 2; rise = 0;
    while (rise == 0 && n < 20) begin
      @(negedge clk); n++;
      if (ce_a) rise = n;
    end
    chk("wake_rise_edge", rise, 4);

    // Busy holds off a pending stop request.
    stop_req = 1'b1; busy = 1'b1; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!ce_a || ack_a || !ce_b || ack_b) bad++;
    end
    chk("busy_blocks_stop", bad, 0);
    busy = 1'b0;
    @(negedge clk);
    chk("stop_ce_a",  ce_a,  0);
    chk("stop_ack_a", ack_a, 1);
    chk("stop_ack_b", ack_b, 1);
    repeat (7) @(negedge clk);
    stop_req = 1'b0;
    @(negedge clk);
    chk("release_ce_a",  ce_a,  1);
    chk("release_ack_a", ack_a, 0);

    // Stop right after CE rose: MIN_ON dwell, then busy/wake ignored.
    stop_req = 1'b1; n = 0; fall = 0;
    while (fall == 0 && n < 20) begin
      @(negedge clk); n++;
      if (ack_a) fall = n;
    end
    chk("min_on_stop_edge", fall, 4);
    busy = 1'b1; wake = 1'b1; bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (ce_a || ce_b) bad++;
    end
    chk("offreq_ignores_busy_wake", bad, 0);
    busy = 1'b0; wake = 1'b0; stop_req = 1'b0;
    @(negedge clk);
    chk("offreq_exit_ce_a", ce_a, 1);

    // Idle-off, then stop request: CE stays low and low dwell keeps counting.
    n = 0; fall = 0;
    while (fall == 0 && n < 40) begin
      @(negedge clk); n++;
      if (!ce_a) fall = n;
    end
    chk("idle_fall_edge2", fall, 17);
    @(negedge clk); bad = ce_a ? 1 : 0;
    stop_req = 1'b1;
    @(negedge clk); if (ce_a) bad++;
    chk("idle_to_req_ack", ack_a, 1);
    chk("idle_to_req_no_glitch", bad, 0);
    stop_req = 1'b0;
    n = 2; rise = 0;
    while (rise == 0 && n < 20) begin
      @(negedge clk); n++;
      if (ce_a) rise = n;
    end
    chk("req_after_idle_rise_edge", rise, 4);

    // Auto-gating disabled on instance b.
    repeat (4) @(negedge clk);
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (!ce_b) low++;
    end
    chk("idle0_never_gates", low, 0);
    stop_req = 1'b1;
    @(negedge clk);
    chk("idle0_stop_ce",  ce_b,  0);
    chk("idle0_stop_ack", ack_b, 1);

    // Reset while stopped, then MIN_ON after release.
    @(negedge clk);
    chk("pre_rst_ack_a", ack_a, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ce_a",  ce_a,  1);
    chk("mid_rst_ack_a", ack_a, 0);
    chk("mid_rst_ce_b",  ce_b,  1);
    rst = 1'b0;
    n = 0; fa = 0; fb = 0;
    while ((fa == 0 || fb == 0) && n < 20) begin
      @(negedge clk); n++;
      if (!ce_a && fa == 0) fa = n;
      if (!ce_b && fb == 0) fb = n;
    end
    chk("rst_min_on_a", fa, 4);
    chk("rst_min_on_b", fb, 4);
    stop_req = 1'b0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
